// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, field widths and the address-match helper.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    I2C_IDLE   = 3'd0,
    I2C_ADDR   = 3'd1,
    I2C_ACK_A  = 3'd2,
    I2C_DATA   = 3'd3,
    I2C_ACK_D  = 3'd4,
    I2C_IGNORE = 3'd5
  } i2c_state_e;

  // True when the received address byte selects this slave for a write.
  function automatic logic i2c_addr_hit(input logic [I2C_BYTE_W-1:0] sh,
                                        input logic [I2C_ADDR_W-1:0] addr);
    return (sh[I2C_BYTE_W-1:1] == addr) && !sh[0];
  endfunction

endpackage

// File: rtl/i2c_slave_rx_if.sv
// Bus pins and byte-delivery handshake of the I2C write-only slave receiver.
interface i2c_slave_rx_if;
  import i2c_pkg::*;

  logic                  scl_in;
  logic                  sda_in;
  logic                  sda_oe;
  logic [I2C_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  busy;
  logic                  stop_det;
  logic                  overflow;

  modport slave (
    input  scl_in, sda_in, rx_ready,
    output sda_oe, rx_data, rx_valid, busy, stop_det, overflow
  );

  modport master (
    output scl_in, sda_in, rx_ready,
    input  sda_oe, rx_data, rx_valid, busy, stop_det, overflow
  );
endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser (reset to bus-idle 1) plus a third flop for rise/fall pulses.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] ff_q;

  always_ff @(posedge clk) begin
    if (rst) ff_q <= 3'b111;
    else     ff_q <= {ff_q[1:0], in_i};
  end

  assign sync_o = ff_q[1];
  assign rise_o = ff_q[1] & ~ff_q[2];
  assign fall_o = ~ff_q[1] & ff_q[2];

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave: START/STOP detection, address match with ACK, MSB-first byte
// capture into a valid/ready holding register with overflow NACK.
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h2A
) (
  input logic           clk,
  input logic           rst,
  i2c_slave_rx_if.slave bus
);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;

  i2c_sync_edge u_scl (
    .clk(clk), .rst(rst), .in_i(bus.scl_in),
    .sync_o(scl_s), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_sync_edge u_sda (
    .clk(clk), .rst(rst), .in_i(bus.sda_in),
    .sync_o(sda_s), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  logic start_c, stop_c;
  assign start_c = sda_fall & scl_s;
  assign stop_c  = sda_rise & scl_s;

  i2c_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0] sh_q, sh_d;
  logic                  ack_q, ack_d;
  logic                  phase_q, phase_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  busy_q, busy_d;
  logic                  stop_det_q, stop_det_d;
  logic                  overflow_q, overflow_d;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  load_c, consume_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= I2C_IDLE;
      bit_cnt_q  <= 3'd7;
      sh_q       <= '0;
      ack_q      <= 1'b0;
      phase_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      stop_det_q <= 1'b0;
      overflow_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      ack_q      <= ack_d;
      phase_q    <= phase_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      stop_det_q <= stop_det_d;
      overflow_q <= overflow_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign consume_c = rx_valid_q & bus.rx_ready;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    ack_d      = ack_q;
    phase_d    = phase_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    stop_det_d = 1'b0;
    overflow_d = overflow_q;
    load_c     = 1'b0;

    // Bus conditions outrank any scl edge seen in the same cycle.
    if (stop_c) begin
      state_d    = I2C_IDLE;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else if (start_c) begin
      state_d   = I2C_ADDR;
      bit_cnt_d = 3'd7;
      sh_d      = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        I2C_ADDR: begin
          if (scl_rise) begin
            sh_d = {sh_q[I2C_BYTE_W-2:0], sda_s};
            if (bit_cnt_q == 3'd0) begin
              if (i2c_addr_hit(sh_d, SLAVE_ADDR)) begin
                state_d = I2C_ACK_A;
                ack_d   = 1'b1;
                busy_d  = 1'b1;
                phase_d = 1'b0;
              end else begin
                state_d = I2C_IGNORE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        I2C_DATA: begin
          if (scl_rise) begin
            sh_d = {sh_q[I2C_BYTE_W-2:0], sda_s};
            if (bit_cnt_q == 3'd0) begin
              state_d = I2C_ACK_D;
              phase_d = 1'b0;
              if (!rx_valid_q || bus.rx_ready) begin
                load_c = 1'b1;
                ack_d  = 1'b1;
              end else begin
                ack_d      = 1'b0;
                overflow_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        // First scl fall opens the ACK slot, the second one closes it.
        I2C_ACK_A, I2C_ACK_D: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = ack_q;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd7;
              state_d   = (state_q == I2C_ACK_D && !ack_q) ? I2C_IGNORE : I2C_DATA;
            end
          end
        end
        default: ;
      endcase
    end

    rx_valid_d = load_c | (rx_valid_q & ~consume_c);
    rx_data_d  = load_c ? sh_d : rx_data_q;
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.stop_det = stop_det_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx acting as an open-drain I2C master on the bus.
module tb_i2c_slave_rx;
  import i2c_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic scl_drv, sda_drv;

  i2c_slave_rx_if bus ();

  assign bus.scl_in = scl_drv;
  assign bus.sda_in = sda_drv & ~bus.sda_oe;

  i2c_slave_rx #(.SLAVE_ADDR(7'h2A)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vld_hi = 0, consumed = 0, stops = 0, oe_cyc = 0;
  logic [7:0] last_data = 8'h00;

  always @(negedge clk) begin
    if (bus.rx_valid) vld_hi <= vld_hi + 1;
    if (bus.rx_valid && bus.rx_ready) begin
      consumed  <= consumed + 1;
      last_data <= bus.rx_data;
    end
    if (bus.stop_det) stops <= stops + 1;
    if (bus.sda_oe) oe_cyc <= oe_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; tick(4);
    scl_drv = 1'b1; tick(8);
    sda_drv = 1'b0; tick(8);
    scl_drv = 1'b0; tick(4);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; tick(4);
    scl_drv = 1'b1; tick(8);
    sda_drv = 1'b1; tick(8);
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b;    tick(4);
    scl_drv = 1'b1; tick(8);
    scl_drv = 1'b0; tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_drv = 1'b1; tick(4);
    scl_drv = 1'b1; tick(4);
    @(negedge clk);
    ack = bus.sda_oe;
    tick(4);
    scl_drv = 1'b0; tick(4);
  endtask

  logic ack;
  int   vld0, cons0, stops0, oe0;

  initial begin
    rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1; bus.rx_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_sda_oe",   bus.sda_oe,   0);
    chk("reset_rx_valid", bus.rx_valid, 0);
    chk("reset_rx_data",  bus.rx_data,  0);
    chk("reset_busy",     bus.busy,     0);
    chk("reset_stop_det", bus.stop_det, 0);
    chk("reset_overflow", bus.overflow, 0);
    tick(4);

    // Addressed write of 0xA5 with the consumer always ready
    vld0 = vld_hi; cons0 = consumed; stops0 = stops;
    i2c_start();
    send_byte(8'h54, ack); chk("t1_addr_ack", ack, 1);
    chk("t1_busy_hi", bus.busy, 1);
    send_byte(8'hA5, ack); chk("t1_data_ack", ack, 1);
    i2c_stop(); tick(6);
    chk("t1_vld_cycles", vld_hi - vld0, 1);
    chk("t1_consumed",   consumed - cons0, 1);
    chk("t1_data",       last_data, 8'hA5);
    chk("t1_stop_det",   stops - stops0, 1);
    chk("t1_busy_lo",    bus.busy, 0);

    // Foreign address: no ACK, no data, parked in IGNORE until STOP
    vld0 = vld_hi; oe0 = oe_cyc;
    i2c_start();
    send_byte(8'h56, ack); chk("t2_addr_nack", ack, 0);
    send_byte(8'h11, ack); chk("t2_data_nack", ack, 0);
    chk("t2_state_ignore", dut.state_q, I2C_IGNORE);
    i2c_stop(); tick(6);
    chk("t2_state_idle", dut.state_q, I2C_IDLE);
    chk("t2_no_oe",      oe_cyc - oe0, 0);
    chk("t2_no_valid",   vld_hi - vld0, 0);

    // Our address with the read bit
    vld0 = vld_hi;
    i2c_start();
    send_byte(8'h55, ack); chk("t3_read_nack", ack, 0);
    i2c_stop(); tick(6);
    chk("t3_no_valid", vld_hi - vld0, 0);

    // Consumer stalled: first byte held, second NACKed with overflow
    bus.rx_ready = 1'b0;
    i2c_start();
    send_byte(8'h54, ack); chk("t4_addr_ack", ack, 1);
    send_byte(8'h01, ack); chk("t4_b1_ack", ack, 1);
    chk("t4_held_valid", bus.rx_valid, 1);
    chk("t4_held_data",  bus.rx_data, 8'h01);
    chk("t4_ovf_before", bus.overflow, 0);
    send_byte(8'h02, ack); chk("t4_b2_nack", ack, 0);
    chk("t4_overflow",  bus.overflow, 1);
    chk("t4_data_kept", bus.rx_data, 8'h01);
    i2c_stop(); tick(6);
    bus.rx_ready = 1'b1; tick(1);
    bus.rx_ready = 1'b0;
    @(negedge clk);
    chk("t4_drained",     bus.rx_valid, 0);
    chk("t4_ovf_sticky",  bus.overflow, 1);
    chk("t4_drained_data", last_data, 8'h01);
    bus.rx_ready = 1'b1;
    tick(4);

    // Repeated START after four data bits discards the partial byte
    vld0 = vld_hi; cons0 = consumed;
    i2c_start();
    send_byte(8'h54, ack); chk("t5_addr_ack", ack, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_start();
    send_byte(8'h54, ack); chk("t5_addr2_ack", ack, 1);
    chk("t5_no_partial", vld_hi - vld0, 0);
    send_byte(8'h3C, ack); chk("t5_data_ack", ack, 1);
    i2c_stop(); tick(6);
    chk("t5_consumed", consumed - cons0, 1);
    chk("t5_data",     last_data, 8'h3C);

    // Reset while the data ACK is being driven, then a normal transfer
    i2c_start();
    send_byte(8'h54, ack); chk("t6_addr_ack", ack, 1);
    for (int i = 7; i >= 0; i--) send_bit(1'b1);
    sda_drv = 1'b1; tick(4);
    scl_drv = 1'b1; tick(2);
    @(negedge clk);
    chk("t6_oe_before_rst", bus.sda_oe, 1);
    tick(1);
    rst = 1'b1; tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_sda_oe",   bus.sda_oe,   0);
    chk("t6_rst_rx_valid", bus.rx_valid, 0);
    chk("t6_rst_rx_data",  bus.rx_data,  0);
    chk("t6_rst_busy",     bus.busy,     0);
    chk("t6_rst_overflow", bus.overflow, 0);
    chk("t6_rst_state",    dut.state_q,  I2C_IDLE);
    tick(2);
    scl_drv = 1'b0; tick(4);
    i2c_stop(); tick(6);
    cons0 = consumed;
    i2c_start();
    send_byte(8'h54, ack); chk("t6_post_addr_ack", ack, 1);
    send_byte(8'h77, ack); chk("t6_post_data_ack", ack, 1);
    i2c_stop(); tick(6);
    chk("t6_post_consumed", consumed - cons0, 1);
    chk("t6_post_data",     last_data, 8'h77);
    chk("t6_post_busy",     bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
